// File: rtl/video_arith_arbiter.sv
// Round-robin arbiter sharing one sequential 12x12 multiplier and one 24/12 divider among NREQ clients.
// Optional macro VIDEO_ARITH_PRIO0_EN gives client 0 absolute priority over the round-robin clients.

// Shift-add multiplier, one multiplier bit per cycle; deliberately has no reset.
module sys_umul #(
  parameter int AW = 12,
  parameter int BW = 12
) (
  input  logic               clk,
  input  logic               start,
  input  logic [AW-1:0]      a,
  input  logic [BW-1:0]      b,
  output logic               run,
  output logic [AW+BW-1:0]   p
);
  localparam int CW = $clog2(BW + 1);

  logic [AW+BW-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [BW-1:0]    mp_q, mp_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next-state for the shift-add iteration.
  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = '0;
      mc_d  = {{BW{1'b0}}, a};
      mp_d  = b;
      cnt_d = CW'(BW);
    end else if (cnt_q != '0) begin
      acc_d = mp_q[0] ? (acc_q + mc_q) : acc_q;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    mc_q  <= mc_d;
    mp_q  <= mp_d;
    cnt_q <= cnt_d;
  end

  assign run = (cnt_q != '0);
  assign p   = acc_q;
endmodule

// Restoring divider, one quotient bit per cycle; deliberately has no reset.
module sys_udiv #(
  parameter int NW = 24,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          run,
  output logic [NW-1:0] q
);
  localparam int CW = $clog2(NW + 1);

  logic [DW-1:0] rem_q, rem_d, den_q, den_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   shl_s;

  // Next-state for one restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    shl_s = {rem_q, quo_q[NW-1]};
    if (start) begin
      rem_d = '0;
      den_d = d;
      quo_d = n;
      cnt_d = CW'(NW);
    end else if (cnt_q != '0) begin
      if (shl_s >= {1'b0, den_q}) begin
        rem_d = DW'(shl_s - {1'b0, den_q});
        quo_d = {quo_q[NW-2:0], 1'b1};
      end else begin
        rem_d = shl_s[DW-1:0];
        quo_d = {quo_q[NW-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    den_q <= den_d;
    quo_q <= quo_d;
    cnt_q <= cnt_d;
  end

  assign run = (cnt_q != '0);
  assign q   = quo_q;
endmodule

module video_arith_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 CLK_VIDEO,
  input  logic                 RESET_N,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*24-1:0]   arg_a,
  input  logic [NREQ*12-1:0]   arg_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [23:0]          res,
  output logic                 div0,
  output logic                 busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_CAPT, ST_DIV0} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic            op_q, op_d, start_q, start_d;
  logic [23:0]     a_q, a_d, res_q, res_d;
  logic [11:0]     b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            div0_q, div0_d, busy_q, busy_d;

  logic [NREQ-1:0] rr_req_s;
  logic [PW-1:0]   win_s;
  logic            found_s, prio_hit_s;
  logic            mul_run_s, div_run_s, eng_run_s;
  logic [23:0]     mul_p_s, div_q_s, eng_res_s;

  sys_umul #(.AW(12), .BW(12)) u_mul (
    .clk   (CLK_VIDEO),
    .start (start_q & ~op_q),
    .a     (a_q[11:0]),
    .b     (b_q),
    .run   (mul_run_s),
    .p     (mul_p_s)
  );

  sys_udiv #(.NW(24), .DW(12)) u_div (
    .clk   (CLK_VIDEO),
    .start (start_q & op_q),
    .n     (a_q),
    .d     (b_q),
    .run   (div_run_s),
    .q     (div_q_s)
  );

  assign eng_run_s = op_q ? div_run_s : mul_run_s;
  assign eng_res_s = op_q ? div_q_s : mul_p_s;

  // Winner search: first requester after the pointer, wrapping modulo NREQ.
  always_comb begin
    rr_req_s   = req;
    win_s      = '0;
    found_s    = 1'b0;
    prio_hit_s = 1'b0;
`ifdef VIDEO_ARITH_PRIO0_EN
    rr_req_s[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && rr_req_s[(int'(ptr_q) + k) % NREQ]) begin
        found_s = 1'b1;
        win_s   = PW'((int'(ptr_q) + k) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
`ifdef VIDEO_ARITH_PRIO0_EN
    if (req[0]) begin
      prio_hit_s = 1'b1;
      found_s    = 1'b1;
      win_s      = '0;
    end else begin
      prio_hit_s = 1'b0;
    end
`endif
  end

  // Operation sequencer: next state and registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    start_d = 1'b0;
    gnt_d   = gnt_q;
    done_d  = '0;
    res_d   = res_q;
    div0_d  = div0_q;
    case (state_q)
      ST_IDLE: begin
        // A run flag may still be high from an operation interrupted by reset.
        if (found_s && !mul_run_s && !div_run_s) begin
          win_d        = win_s;
          ptr_d        = prio_hit_s ? ptr_q : win_s;
          op_d         = op[win_s];
          a_d          = arg_a[int'(win_s)*24 +: 24];
          b_d          = arg_b[int'(win_s)*12 +: 12];
          gnt_d        = '0;
          gnt_d[win_s] = 1'b1;
          if (op[win_s] && (arg_b[int'(win_s)*12 +: 12] == 12'd0)) begin
            state_d = ST_DIV0;
          end else begin
            state_d = ST_START;
            start_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!start_q && !eng_run_s) begin
          state_d = ST_CAPT;
          if (req[win_q]) begin
            res_d         = eng_res_s;
            div0_d        = 1'b0;
            done_d[win_q] = 1'b1;
          end else begin
            res_d = res_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DIV0: begin
        state_d = ST_CAPT;
        if (req[win_q]) begin
          res_d         = 24'hFFFFFF;
          div0_d        = 1'b1;
          done_d[win_q] = 1'b1;
        end else begin
          res_d = res_q;
        end
      end
      ST_CAPT: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= 24'd0;
      b_q     <= 12'd0;
      start_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= 24'd0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign res  = res_q;
  assign div0 = div0_q;
  assign busy = busy_q;
endmodule
